// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StPresent,
    StCheck,
    StDone,
    StErr
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

  // Bytes arrive most-significant first: lane 0 lands in wInst[31:24].
  localparam int unsigned NumLanes  = 4;
  localparam logic [1:0]  LaneFirst = 2'd0;
  localparam logic [1:0]  LaneLast  = 2'd3;

endpackage

// File: rtl/inst_boot_loader_if.sv
// Byte-stream input and instruction-memory load port of the boot loader.
interface inst_boot_loader_if #(
  parameter int unsigned ADDR_W = 7
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              IWEN;
  logic [ADDR_W-1:0] I_Addr;
  logic [31:0]       wInst;
  logic              load_done;
  logic              load_err;
  logic [7:0]        word_cnt;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, IWEN, I_Addr, wInst, load_done, load_err, word_cnt
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, IWEN, I_Addr, wInst, load_done, load_err, word_cnt
  );
endinterface

// File: rtl/boot_word_packer.sv
// Packs accepted payload bytes MSB-first into 32-bit words and keeps the running XOR checksum.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  input  logic        clear,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic [7:0]  csum
);

  logic [1:0]  lane_q;
  logic [23:0] shift_q;
  logic [7:0]  csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q  <= LaneFirst;
      shift_q <= '0;
      csum_q  <= '0;
    end else if (clear) begin
      lane_q  <= LaneFirst;
      shift_q <= '0;
      csum_q  <= '0;
    end else if (byte_en) begin
      lane_q  <= lane_q + 2'd1;
      shift_q <= {shift_q[15:0], byte_in};
      csum_q  <= csum_q ^ byte_in;
    end
  end

  // The completed word is offered in the same cycle its last byte is accepted.
  assign word_out   = {shift_q, byte_in};
  assign word_valid = byte_en && (lane_q == LaneLast);
  assign csum       = csum_q;

endmodule

// File: rtl/inst_boot_loader.sv
// Frame parser driving the instruction-memory load port from a SYNC/len/payload/checksum stream.
module inst_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  inst_boot_loader_if.slave bus
);

  localparam int unsigned     HoldW    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned     ToW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       inst_q, inst_d;
  logic              err_q, err_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [ToW-1:0]    to_q, to_d;

  logic        ready, accept, waiting, sync_seen;
  logic [31:0] word;
  logic        word_valid;
  logic [7:0]  csum;

  // Gating with rst keeps the source stalled for the whole reset pulse.
  assign ready     = !rst && (state_q inside {StIdle, StLen, StData, StCheck});
  assign waiting   = state_q inside {StLen, StData, StCheck};
  assign accept    = bus.rx_valid && ready;
  assign sync_seen = accept && (state_q == StIdle) && (bus.rx_data == SYNC_BYTE);

  boot_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (bus.rx_data),
    .byte_en    (accept && (state_q == StData)),
    .clear      (sync_seen),
    .word_out   (word),
    .word_valid (word_valid),
    .csum       (csum)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    err_d      = err_q;
    hold_d     = hold_q;
    to_d       = to_q;

    // Idle-gap watchdog; an accepted byte on the expiring cycle overrides it below.
    if (waiting && !accept) begin
      if (to_q == ToLast) state_d = StErr;
      else                to_d    = to_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (sync_seen) begin
          state_d    = StLen;
          err_d      = 1'b0;
          word_cnt_d = '0;
          to_d       = '0;
        end
      end
      StLen: begin
        if (accept) begin
          to_d = '0;
          if (bus.rx_data == 8'd0 || {24'd0, bus.rx_data} > DEPTH) begin
            state_d = StErr;
          end else begin
            len_d   = bus.rx_data;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          to_d    = '0;
          state_d = StData;
          if (word_valid) begin
            inst_d  = word;
            addr_d  = ADDR_W'(word_cnt_q);
            hold_d  = '0;
            state_d = StPresent;
          end
        end
      end
      StPresent: begin
        if (hold_q == HoldLast) begin
          word_cnt_d = word_cnt_q + 8'd1;
          state_d    = (word_cnt_d == len_q) ? StCheck : StData;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StCheck: begin
        if (accept) begin
          to_d    = '0;
          state_d = (bus.rx_data == csum) ? StDone : StErr;
        end
      end
      StDone: state_d = StIdle;
      StErr: begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      inst_q     <= '0;
      err_q      <= 1'b0;
      hold_q     <= '0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
      to_q       <= to_d;
    end
  end

  assign bus.rx_ready  = ready;
  assign bus.IWEN      = waiting || (state_q == StPresent);
  assign bus.I_Addr    = addr_q;
  assign bus.wInst     = inst_q;
  assign bus.load_done = (state_q == StDone);
  assign bus.load_err  = err_q;
  assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_inst_boot_loader.sv
// Randomized frame stimulus with a frame-level reference model and a scoreboard monitor.
module tb_inst_boot_loader;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DEPTH    = 128;
  localparam int unsigned HOLD_CYC = 2;
  localparam int unsigned TIMEOUT  = 1024;
  localparam logic [7:0]  SYNC     = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_boot_loader #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .HOLD_CYC  (HOLD_CYC),
    .TIMEOUT   (TIMEOUT),
    .SYNC_BYTE (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [39:0] exp_words[$];  // {addr, word} in presentation order
  int          exp_res[$];    // -1 = error expected, else word_cnt at load_done
  logic [7:0]  fr_b[$];
  int          fr_g[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares every presented word and every frame outcome against the queues.
  initial begin : monitor
    int          run_len;
    logic [39:0] cur;
    logic        err_prev;
    int          r;
    run_len  = 0;
    err_prev = 1'b0;
    cur      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_len  = 0;
        err_prev = 1'b0;
      end else begin
        if (bus.IWEN && !bus.rx_ready) begin
          if (run_len == 0) begin
            chk("word_expected", 64'(exp_words.size() != 0), 64'd1);
            cur = (exp_words.size() != 0) ? exp_words.pop_front() : '1;
          end
          chk("word_addr", 64'(bus.I_Addr), 64'(cur[39:32]));
          chk("word_data", 64'(bus.wInst), 64'(cur[31:0]));
          run_len++;
        end else if (run_len != 0) begin
          chk("hold_cycles", 64'(run_len), 64'(HOLD_CYC));
          run_len = 0;
        end
        if (bus.load_done) begin
          chk("done_expected", 64'(exp_res.size() != 0), 64'd1);
          r = (exp_res.size() != 0) ? exp_res.pop_front() : -2;
          chk("result_is_done", 64'(r >= 0), 64'd1);
          chk("done_word_cnt", 64'(bus.word_cnt), 64'(r));
          chk("iwen_low_at_done", 64'(bus.IWEN), 64'd0);
        end
        if (bus.load_err && !err_prev) begin
          chk("err_expected", 64'(exp_res.size() != 0), 64'd1);
          r = (exp_res.size() != 0) ? exp_res.pop_front() : -2;
          chk("result_is_err", 64'(r == -1), 64'd1);
          chk("iwen_low_at_err", 64'(bus.IWEN), 64'd0);
        end
        err_prev = bus.load_err;
      end
    end
  end

  // Frame-level model: walks the frame bytes, predicting words, timeouts and the outcome.
  task automatic model_frame(output int n_send, output int tail, output bit e, output int wc);
    int          n, idle, idx;
    logic [7:0]  cs;
    logic [31:0] w;
    e = 1'b0; wc = 0; tail = 0; cs = '0; w = '0;
    n_send = fr_b.size();
    n = int'(fr_b[1]);
    if (fr_g[1] >= int'(TIMEOUT)) begin
      n_send = 1; tail = fr_g[1]; e = 1'b1;
    end else if (n == 0 || n > int'(DEPTH)) begin
      n_send = 2; e = 1'b1;
    end else begin
      for (int k = 0; k <= 4 * n; k++) begin
        idx  = 2 + k;
        idle = (k > 0 && k % 4 == 0) ? fr_g[idx] - int'(HOLD_CYC) : fr_g[idx];
        if (idle >= int'(TIMEOUT)) begin
          n_send = idx; tail = fr_g[idx]; e = 1'b1;
          break;
        end
        if (k < 4 * n) begin
          cs ^= fr_b[idx];
          w = {w[23:0], fr_b[idx]};
          if (k % 4 == 3) begin
            exp_words.push_back({8'(k / 4), w});
            wc = k / 4 + 1;
          end
        end else begin
          e = (fr_b[idx] != cs);
        end
      end
    end
    exp_res.push_back(e ? -1 : wc);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) @(posedge clk);
    #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    if (!ok) chk("ready_wait", 64'd0, 64'd1);
  endtask

  task automatic build(input logic [7:0] nf, input int maxgap, input bit bad);
    int         nw;
    logic [7:0] x, cs;
    fr_b.delete();
    fr_g.delete();
    cs = '0;
    nw = (nf == 8'd0 || int'(nf) > int'(DEPTH)) ? 0 : int'(nf);
    fr_b.push_back(SYNC);
    fr_b.push_back(nf);
    for (int i = 0; i < 4 * nw; i++) begin
      x = 8'($urandom);
      fr_b.push_back(x);
      cs ^= x;
    end
    if (nw > 0) fr_b.push_back(bad ? cs ^ 8'($urandom_range(1, 255)) : cs);
    for (int i = 0; i < fr_b.size(); i++) fr_g.push_back(int'($urandom_range(0, maxgap)));
  endtask

  task automatic zero_gaps();
    fr_g.delete();
    for (int i = 0; i < fr_b.size(); i++) fr_g.push_back(0);
  endtask

  task automatic run_frame();
    int n_send, tail, wc;
    bit e;
    model_frame(n_send, tail, e, wc);
    for (int i = 0; i < n_send; i++) begin
      send_byte(fr_b[i], fr_g[i]);
      if (i == 0) begin
        chk("iwen_after_sync", 64'(bus.IWEN), 64'd1);
        chk("err_clear_at_sync", 64'(bus.load_err), 64'd0);
      end
    end
    repeat (tail + int'(HOLD_CYC) + 4) @(posedge clk);
    #1;
    chk("end_iwen", 64'(bus.IWEN), 64'd0);
    chk("end_load_err", 64'(bus.load_err), 64'(e));
    chk("end_word_cnt", 64'(bus.word_cnt), 64'(wc));
    chk("end_results_drained", 64'(exp_res.size()), 64'd0);
    chk("end_words_drained", 64'(exp_words.size()), 64'd0);
  endtask

  task automatic garbage(input int count);
    logic [7:0] x;
    for (int i = 0; i < count; i++) begin
      do x = 8'($urandom); while (x == SYNC);
      send_byte(x, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] nf;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;

    #2;
    chk("rst_iwen", 64'(bus.IWEN), 64'd0);
    chk("rst_ready", 64'(bus.rx_ready), 64'd0);
    chk("rst_addr", 64'(bus.I_Addr), 64'd0);
    chk("rst_inst", 64'(bus.wInst), 64'd0);
    chk("rst_done", 64'(bus.load_done), 64'd0);
    chk("rst_err", 64'(bus.load_err), 64'd0);
    chk("rst_word_cnt", 64'(bus.word_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_rst", 64'(bus.rx_ready), 64'd1);

    // Directed good frame, back-to-back bytes with rx_valid held high.
    fr_b = '{SYNC, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h6F, 8'h6C};
    zero_gaps();
    run_frame();

    // Same frame with a bad checksum, then a good one that must clear load_err.
    fr_b[10] = 8'h00;
    run_frame();
    chk("err_sticky", 64'(bus.load_err), 64'd1);
    build(8'd3, 1, 1'b0);
    run_frame();

    // Length boundaries.
    fr_b = '{SYNC, 8'h00};
    zero_gaps();
    run_frame();
    fr_b = '{SYNC, 8'h81};
    zero_gaps();
    run_frame();
    build(8'd128, 0, 1'b0);
    run_frame();

    // Timeout expires after exactly TIMEOUT idle cycles; one cycle earlier is fine.
    build(8'd1, 0, 1'b0);
    fr_g[3] = int'(TIMEOUT);
    run_frame();
    build(8'd1, 0, 1'b0);
    fr_g[3] = int'(TIMEOUT) - 1;
    run_frame();

    // Randomized frames with line noise before SYNC.
    for (int f = 0; f < 16; f++) begin
      garbage(int'($urandom_range(0, 3)));
      nf = 8'($urandom_range(1, 6));
      if (f == 7) nf = 8'd0;
      if (f == 11) nf = 8'd200;
      build(nf, 3, ($urandom_range(0, 3) == 0));
      run_frame();
    end

    // Asynchronous reset in the middle of the second word.
    fr_b = '{SYNC, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    exp_words.push_back({8'd0, 32'h12345678});
    for (int i = 0; i < 8; i++) send_byte(fr_b[i], 0);
    chk("pre_rst_inst", 64'(bus.wInst), 64'h12345678);
    chk("pre_rst_word_cnt", 64'(bus.word_cnt), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_iwen", 64'(bus.IWEN), 64'd0);
    chk("async_rst_addr", 64'(bus.I_Addr), 64'd0);
    chk("async_rst_inst", 64'(bus.wInst), 64'd0);
    chk("async_rst_word_cnt", 64'(bus.word_cnt), 64'd0);
    chk("async_rst_ready", 64'(bus.rx_ready), 64'd0);
    chk("words_drained_pre_rst", 64'(exp_words.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_rst2", 64'(bus.rx_ready), 64'd1);
    garbage(5);
    build(8'd2, 2, 1'b0);
    run_frame();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
